// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: byte width, header length field,
// default FIFO sizing and the router FSM state encodings.
package router_pkg;

  localparam int ROUTER_DATA_W         = 8;
  localparam int ROUTER_LEN_MSB        = 7;
  localparam int ROUTER_LEN_LSB        = 2;
  localparam int ROUTER_FIFO_DEPTH     = 16;
  localparam int ROUTER_TIMEOUT_CYCLES = 30;

  // Router FSM states, exported so benches can correlate FIFO activity with the FSM.
  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_READ  = 2'd1,
    FSM_WRITE = 2'd2,
    FSM_RESET = 2'd3
  } router_fsm_state_e;

  // Bytes still to come after a header: payload length plus the parity byte.
  function automatic logic [6:0] hdr_pkt_count(input logic [ROUTER_DATA_W-1:0] hdr_byte);
    return {1'b0, hdr_byte[ROUTER_LEN_MSB:ROUTER_LEN_LSB]} + 7'd1;
  endfunction

endpackage

// File: rtl/router_fifo_timer.sv
// Idle-read timer for router_fifo. Down-counter loaded with TIMEOUT_CYCLES;
// each idle cycle consumes one count and expire is the terminal count (zero).
// Only instantiated when ROUTER_FIFO_TIMEOUT_EN is defined.
module router_fifo_timer #(
  parameter int TIMEOUT_CYCLES = 30
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] remain;

  // Reload on clear, otherwise count down idle cycles and hold at terminal count.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      remain <= LOAD;
    end else if (clear) begin
      remain <= LOAD;
    end else if (count_en && (remain != '0)) begin
      remain <= remain - ONE;
    end
  end

  assign expire = (remain == '0);

endmodule

// File: rtl/router_fifo.sv
// Per-destination packet buffer of the 1x3 router. Stores {hdr, byte} entries,
// returns them through a registered output and tracks packet ends on the read
// side. Optional idle-read auto-flush is enabled by ROUTER_FIFO_TIMEOUT_EN.
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH          = ROUTER_FIFO_DEPTH,
  parameter int DATA_W         = ROUTER_DATA_W,
  parameter int TIMEOUT_CYCLES = ROUTER_TIMEOUT_CYCLES
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enb,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              pkt_last,
  output logic              full,
  output logic              empty,
  output logic              timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DATA_W:0] mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [6:0]      pkt_cnt;
  logic [DATA_W:0] rd_entry;
  logic            flush;
  logic            tmo_hit;
  logic            push;
  logic            pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // Flush beats any concurrent push or pop; flags are the pre-edge view.
  assign flush    = soft_reset || tmo_hit;
  assign push     = write_enb && !full && !flush;
  assign pop      = read_enb && !empty && !flush;
  assign rd_entry = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  // Read and write pointers, one extra bit to tell full from empty.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Packet counter: a header (re)loads it, body bytes count it down to the parity byte.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pkt_cnt <= '0;
    end else if (flush) begin
      pkt_cnt <= '0;
    end else if (pop) begin
      if (rd_entry[DATA_W]) begin
        pkt_cnt <= hdr_pkt_count(rd_entry[ROUTER_DATA_W-1:0]);
      end else if (pkt_cnt != '0) begin
        pkt_cnt <= pkt_cnt - 7'd1;
      end
    end
  end

  // Registered output byte with single-cycle valid and end-of-packet strobes.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      pkt_last   <= 1'b0;
    end else if (flush) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      pkt_last   <= 1'b0;
    end else begin
      data_valid <= pop;
      pkt_last   <= pop && !rd_entry[DATA_W] && (pkt_cnt == 7'd1);
      if (pop) data_out <= rd_entry[DATA_W-1:0];
    end
  end

`ifdef ROUTER_FIFO_TIMEOUT_EN
  logic tmo_expire;

  router_fifo_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock    (clock),
    .resetn   (resetn),
    .clear    ((read_enb && !empty) || empty || flush),
    .count_en (!empty && !read_enb),
    .expire   (tmo_expire)
  );

  assign tmo_hit = tmo_expire;

  // Timeout strobe accompanies the auto-flush; an explicit soft reset suppresses it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      timeout <= 1'b0;
    end else begin
      timeout <= tmo_expire && !soft_reset;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule
